// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler for the 640x480 TMDS path.
// Delays the timing signals by 11 cycles so each video period can be
// announced by an 8-cycle preamble and a 2-cycle guard band. It also grants
// data-island slots to one packet source during horizontal blanking.
module hdmi_period_scheduler #(
    parameter int ISL_START = 16,
    parameter int MAX_PKTS  = 2
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pkt_req,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [2:0] mode,
    output logic [3:0] ctl,
    output logic [4:0] pkt_idx,
    output logic       pkt_ack,
    output logic       err
);

    typedef enum logic [2:0] {
        CTRL     = 3'd0,
        VID_PRE  = 3'd1,
        VID_GB   = 3'd2,
        VIDEO    = 3'd3,
        ISL_PRE  = 3'd4,
        ISL_LGB  = 3'd5,
        ISL_DATA = 3'd6,
        ISL_TGB  = 3'd7
    } mode_t;

    localparam int         DLY         = 11;
    localparam logic [7:0] W_ISL_START = 8'(ISL_START);
    localparam logic [2:0] W_MAX_PKTS  = 3'(MAX_PKTS);

    // Each stage holds {de, hsync, vsync}; stage 1 sits in bits [2:0].
    logic [3*DLY-1:0] r_sr;
    logic [7:0]       r_blank_cnt;
    mode_t            r_mode;
    mode_t            w_mode_next;
    logic [2:0]       r_phase;
    logic [2:0]       w_phase_next;
    logic [4:0]       r_pkt_idx;
    logic [4:0]       w_idx_next;
    logic [2:0]       r_pkt_cnt;
    logic [2:0]       w_cnt_next;
    logic             r_err;
    logic             w_err_next;
    logic [3:0]       r_ctl;
    logic [3:0]       w_ctl_next;
    logic             r_ack;
    logic             w_ack_next;

    logic w_de_prev;
    logic w_de_s10;
    logic w_rise;

    assign w_de_prev = r_sr[2];
    assign w_de_s10  = r_sr[3*9+2];
    assign w_rise    = de_in & ~w_de_prev;

    assign de_o    = r_sr[3*DLY-1];
    assign hsync_o = r_sr[3*DLY-2];
    assign vsync_o = r_sr[3*DLY-3];
    assign mode    = r_mode;
    assign ctl     = r_ctl;
    assign pkt_idx = r_pkt_idx;
    assign pkt_ack = r_ack;
    assign err     = r_err;

    // Timing-signal delay line and blanking-length counter.
    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            r_sr        <= '0;
            r_blank_cnt <= 8'd0;
        end else begin
            r_sr <= {r_sr[3*(DLY-1)-1:0], de_in, hsync_in, vsync_in};
            if (de_o)
                r_blank_cnt <= 8'd0;
            else if (r_blank_cnt != 8'hFF)
                r_blank_cnt <= r_blank_cnt + 8'd1;
        end
    end

    // Period state register plus the outputs that must line up with it.
    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            r_mode    <= CTRL;
            r_phase   <= 3'd0;
            r_pkt_idx <= 5'd0;
            r_pkt_cnt <= 3'd0;
            r_err     <= 1'b0;
            r_ctl     <= 4'd0;
            r_ack     <= 1'b0;
        end else begin
            r_mode    <= w_mode_next;
            r_phase   <= w_phase_next;
            r_pkt_idx <= w_idx_next;
            r_pkt_cnt <= w_cnt_next;
            r_err     <= w_err_next;
            r_ctl     <= w_ctl_next;
            r_ack     <= w_ack_next;
        end
    end

    // Next period selection; a video start always wins over a running island.
    always_comb begin
        w_mode_next  = r_mode;
        w_phase_next = r_phase + 3'd1;
        w_idx_next   = 5'd0;
        w_cnt_next   = r_pkt_cnt;
        w_err_next   = r_err;
        case (r_mode)
            CTRL: begin
                w_phase_next = 3'd0;
                w_cnt_next   = 3'd0;
                if (w_rise)
                    w_mode_next = VID_PRE;
                else if (r_blank_cnt == W_ISL_START && pkt_req)
                    w_mode_next = ISL_PRE;
            end
            VID_PRE: begin
                if (r_phase == 3'd7) begin
                    w_mode_next  = VID_GB;
                    w_phase_next = 3'd0;
                end
            end
            VID_GB: begin
                if (r_phase == 3'd1) begin
                    w_mode_next  = VIDEO;
                    w_phase_next = 3'd0;
                end
            end
            VIDEO: begin
                // Stage 10 looks one cycle ahead so mode tracks de_o exactly.
                w_phase_next = 3'd0;
                if (!w_de_s10)
                    w_mode_next = CTRL;
            end
            ISL_PRE: begin
                if (r_phase == 3'd7) begin
                    w_mode_next  = ISL_LGB;
                    w_phase_next = 3'd0;
                end
            end
            ISL_LGB: begin
                if (r_phase == 3'd1) begin
                    w_mode_next  = ISL_DATA;
                    w_phase_next = 3'd0;
                    w_cnt_next   = 3'd1;
                end
            end
            ISL_DATA: begin
                w_phase_next = 3'd0;
                w_idx_next   = r_pkt_idx + 5'd1;
                if (r_pkt_idx == 5'd31) begin
                    w_idx_next = 5'd0;
                    if (pkt_req && r_pkt_cnt < W_MAX_PKTS)
                        w_cnt_next = r_pkt_cnt + 3'd1;
                    else
                        w_mode_next = ISL_TGB;
                end
            end
            ISL_TGB: begin
                if (r_phase == 3'd1) begin
                    w_mode_next  = CTRL;
                    w_phase_next = 3'd0;
                end
            end
            default: begin
                w_mode_next  = CTRL;
                w_phase_next = 3'd0;
            end
        endcase

        if (w_rise && r_mode[2]) begin
            w_err_next   = 1'b1;
            w_mode_next  = VID_PRE;
            w_phase_next = 3'd0;
            w_idx_next   = 5'd0;
        end

        case (w_mode_next)
            VID_PRE: w_ctl_next = 4'b0001;
            ISL_PRE: w_ctl_next = 4'b0101;
            default: w_ctl_next = 4'b0000;
        endcase
        w_ack_next = (w_mode_next == ISL_DATA) && (w_idx_next == 5'd0);
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: per-cycle expected periods are
// queued as each stimulus segment is issued, then popped and compared every
// cycle together with the 11-cycle delayed timing signals.
module tb_hdmi_period_scheduler;

    logic       clk_pix = 1'b0;
    logic       rst_in = 1'b1;
    logic       de_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       pkt_req = 1'b0;
    logic       de_o, hsync_o, vsync_o;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic [4:0] pkt_idx;
    logic       pkt_ack;
    logic       err;

    localparam logic [2:0] M_CTRL = 3'd0, M_VPRE = 3'd1, M_VGB = 3'd2, M_VID = 3'd3,
                           M_IPRE = 3'd4, M_ILGB = 3'd5, M_IDAT = 3'd6, M_ITGB = 3'd7;

    always #5 clk_pix = ~clk_pix;

    hdmi_period_scheduler #(.ISL_START(16), .MAX_PKTS(2)) dut (
        .clk_pix (clk_pix),
        .rst_in  (rst_in),
        .de_in   (de_in),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .pkt_req (pkt_req),
        .de_o    (de_o),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .mode    (mode),
        .ctl     (ctl),
        .pkt_idx (pkt_idx),
        .pkt_ack (pkt_ack),
        .err     (err)
    );

    typedef struct packed {
        logic [2:0] em;
        logic [4:0] eidx;
        logic       eack;
        logic       eerr;
    } exp_t;

    exp_t       mq[$];
    logic [2:0] dq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       exp_err = 1'b0;
    logic       req_v = 1'b0;
    logic       drop_on_ack = 1'b0;

    function automatic logic [3:0] ctl_of(input logic [2:0] m);
        if (m == M_VPRE) return 4'b0001;
        if (m == M_IPRE) return 4'b0101;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push_n(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++)
            mq.push_back('{em: m, eidx: 5'd0, eack: 1'b0, eerr: exp_err});
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++)
            mq.push_back('{em: M_IDAT, eidx: 5'(i % 32), eack: ((i % 32) == 0), eerr: exp_err});
    endtask

    task automatic push_island(input int npk);
        push_n(M_IPRE, 8);
        push_n(M_ILGB, 2);
        push_data(32 * npk);
        push_n(M_ITGB, 2);
    endtask

    task automatic push_vid(input int n);
        push_n(M_VPRE, 8);
        push_n(M_VGB, 2);
        push_n(M_VID, n);
    endtask

    // Sample this cycle's outputs and compare against the scoreboards.
    task automatic tick();
        exp_t       e;
        logic [2:0] d;
        @(posedge clk_pix);
        #1;
        cyc++;
        chk("dly_avail", 32'(dq.size() > 0), 32'd1);
        chk("exp_avail", 32'(mq.size() > 0), 32'd1);
        d = (dq.size() > 0) ? dq.pop_front() : 3'd0;
        e = (mq.size() > 0) ? mq.pop_front() : '0;
        chk("de_o", 32'(de_o), 32'(d[2]));
        chk("hsync_o", 32'(hsync_o), 32'(d[1]));
        chk("vsync_o", 32'(vsync_o), 32'(d[0]));
        chk("mode", 32'(mode), 32'(e.em));
        chk("ctl", 32'(ctl), 32'(ctl_of(e.em)));
        chk("pkt_idx", 32'(pkt_idx), 32'(e.eidx));
        chk("pkt_ack", 32'(pkt_ack), 32'(e.eack));
        chk("err", 32'(err), 32'(e.eerr));
        if (pkt_ack) begin
            $display("cyc=%0d packet granted mode=%0d err=%0d", cyc, mode, err);
            if (drop_on_ack) begin
                req_v = 1'b0;
                drop_on_ack = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic de);
        de_in    = de;
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        pkt_req  = req_v;
        dq.push_back({de_in, hsync_in, vsync_in});
    endtask

    task automatic run(input logic de, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(de);
        end
    endtask

    task automatic do_reset(input int n);
        rst_in   = 1'b1;
        de_in    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        pkt_req  = 1'b0;
        req_v    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pix);
            #1;
            cyc++;
        end
        chk("rst_mode", 32'(mode), 32'(M_CTRL));
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_idx", 32'(pkt_idx), 32'd0);
        chk("rst_ack", 32'(pkt_ack), 32'd0);
        chk("rst_de_o", 32'(de_o), 32'd0);
        chk("rst_hsync_o", 32'(hsync_o), 32'd0);
        chk("rst_vsync_o", 32'(vsync_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        $display("cyc=%0d reset applied for %0d cycle(s)", cyc, n);
        mq.delete();
        dq.delete();
        for (int i = 0; i < 11; i++) dq.push_back(3'd0);
        exp_err = 1'b0;
        rst_in  = 1'b0;
    endtask

    initial begin
        do_reset(3);

        // Two plain lines, no packet source.
        push_n(M_CTRL, 21); push_vid(640);
        run(1'b0, 20); run(1'b1, 640);
        push_n(M_CTRL, 150); push_vid(640);
        run(1'b0, 160); run(1'b1, 640);

        // Request held: two packets in the following blanking.
        req_v = 1'b1;
        push_n(M_CTRL, 17); push_island(2); push_n(M_CTRL, 57); push_vid(640);
        run(1'b0, 160); run(1'b1, 640);

        // Source withdraws after the first grant: one packet only.
        drop_on_ack = 1'b1;
        push_n(M_CTRL, 17); push_island(1); push_n(M_CTRL, 89); push_vid(640);
        run(1'b0, 160); run(1'b1, 640);

        // Short blanking: de_in rises during packet data, island aborted.
        req_v = 1'b1;
        push_n(M_CTRL, 17); push_n(M_IPRE, 8); push_n(M_ILGB, 2); push_data(20);
        exp_err = 1'b1;
        push_vid(640);
        run(1'b0, 57); run(1'b1, 640);

        // Reset while pkt_idx==10.
        push_n(M_CTRL, 17); push_n(M_IPRE, 8); push_n(M_ILGB, 2); push_data(11);
        run(1'b0, 48);
        tick();
        do_reset(1);

        // After release the island starts again at blank_cnt==16.
        req_v = 1'b1;
        push_n(M_CTRL, 16); push_island(2); push_n(M_CTRL, 28); push_vid(640);
        run(1'b0, 119); run(1'b1, 640);
        req_v = 1'b0;
        push_n(M_CTRL, 29);
        run(1'b0, 40);

        chk("exp_drained", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
